// File: rtl/multi_crop_fifo.sv
// Streaming multi-window crop: raster-scans a frame, tags pixels that fall in one of
// NUM_CROPS run-time windows with {crop_id, last} and buffers them in an output FIFO.
module multi_crop_fifo #(
   parameter int PIXEL_BIT_WIDTH = 8,
   parameter int CHANNELS        = 1,
   parameter int IN_ROWS         = 9,
   parameter int IN_COLS         = 9,
   parameter int OUT_ROWS        = 3,
   parameter int OUT_COLS        = 3,
   parameter int NUM_CROPS       = 2,
   parameter int FIFO_DEPTH      = 16,
   localparam int RW = $clog2(IN_ROWS),
   localparam int CW = $clog2(IN_COLS),
   localparam int IW = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1,
   localparam int DW = PIXEL_BIT_WIDTH * CHANNELS
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_CROPS*RW-1:0] cfg_y1,
   input  logic [NUM_CROPS*CW-1:0] cfg_x1,
   input  logic [NUM_CROPS-1:0]    cfg_en,
   input  logic [DW-1:0]           pixel_in,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [DW-1:0]           pixel_out,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [IW-1:0]           out_crop_id,
   output logic                    out_last,
   output logic                    frame_done,
   output logic [NUM_CROPS-1:0]    cfg_err
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic {IDLE, STREAM} state_t;

   typedef struct packed {
      logic [IW-1:0] id;
      logic          last;
      logic [DW-1:0] pix;
   } entry_t;

   state_t                  state, state_nx;
   logic [RW-1:0]           row;
   logic [CW-1:0]           col;
   logic [NUM_CROPS*RW-1:0] y1_q, y1_e;
   logic [NUM_CROPS*CW-1:0] x1_q, x1_e;
   logic [NUM_CROPS-1:0]    en_q, en_e;
   logic [NUM_CROPS-1:0]    cvalid, inwin, atlast;
   logic                    accept, latch, last_beat;
   logic                    hit, hit_last;
   logic [IW-1:0]           hit_id;

   entry_t                  mem [FIFO_DEPTH];
   entry_t                  head;
   logic [AW:0]             wptr, rptr;
   logic                    full, push, pop;

   assign accept    = in_valid & in_ready;
   assign latch     = accept & (state == IDLE);
   assign last_beat = (row == RW'(IN_ROWS - 1)) && (col == CW'(IN_COLS - 1));

   // The first beat of a frame must already see the config it latches.
   assign y1_e = (state == IDLE) ? cfg_y1 : y1_q;
   assign x1_e = (state == IDLE) ? cfg_x1 : x1_q;
   assign en_e = (state == IDLE) ? cfg_en : en_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:   if (accept && !last_beat) state_nx = STREAM;
         STREAM: if (accept && last_beat)  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row        <= '0;
         col        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= accept & last_beat;
         if (accept) begin
            if (col == CW'(IN_COLS - 1)) begin
               col <= '0;
               row <= last_beat ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         y1_q    <= '0;
         x1_q    <= '0;
         en_q    <= '0;
         cfg_err <= '0;
      end else if (latch) begin
         y1_q    <= cfg_y1;
         x1_q    <= cfg_x1;
         en_q    <= cfg_en;
         cfg_err <= cfg_en & ~cvalid;
      end
   end

   // Window bounds are computed one bit wide of the coordinate so y1+OUT_ROWS never wraps.
   for (genvar k = 0; k < NUM_CROPS; k++) begin : g_crop
      logic [RW:0] y0, yend, r;
      logic [CW:0] x0, xend, c;
      assign y0   = {1'b0, y1_e[k*RW +: RW]};
      assign x0   = {1'b0, x1_e[k*CW +: CW]};
      assign yend = y0 + (RW+1)'(OUT_ROWS);
      assign xend = x0 + (CW+1)'(OUT_COLS);
      assign r    = {1'b0, row};
      assign c    = {1'b0, col};
      assign cvalid[k] = en_e[k] && (yend <= (RW+1)'(IN_ROWS)) && (xend <= (CW+1)'(IN_COLS));
      assign inwin[k]  = cvalid[k] && (r >= y0) && (r < yend) && (c >= x0) && (c < xend);
      assign atlast[k] = (r == yend - 1'b1) && (c == xend - 1'b1);
   end

   always_comb begin
      hit      = 1'b0;
      hit_id   = '0;
      hit_last = 1'b0;
      for (int k = NUM_CROPS - 1; k >= 0; k--) begin
         if (inwin[k]) begin
            hit      = 1'b1;
            hit_id   = IW'(k);
            hit_last = atlast[k];
         end
      end
   end

   assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign out_valid = (wptr != rptr);
   assign in_ready = reset_n & ~full;
   assign push     = accept & hit;
   assign pop      = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= '{id: hit_id, last: hit_last, pix: pixel_in};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   assign head        = mem[rptr[AW-1:0]];
   assign pixel_out   = out_valid ? head.pix  : '0;
   assign out_crop_id = out_valid ? head.id   : '0;
   assign out_last    = out_valid ? head.last : 1'b0;
endmodule

// File: tb/tb_multi_crop_fifo.sv
// Directed bench for multi_crop_fifo: 9x9 frames of raster-index pixels, hand-computed crop streams.
module tb_multi_crop_fifo;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [7:0]    cfg_y1, cfg_x1;
   logic [1:0]    cfg_en;
   logic [DW-1:0] pixel_in;
   logic          in_valid, in_ready;
   logic [DW-1:0] pixel_out;
   logic          out_valid, out_ready;
   logic          out_crop_id, out_last, frame_done;
   logic [1:0]    cfg_err;

   int checks = 0;
   int errors = 0;
   int gp[$], gi[$], gl[$], ep[$], ei[$], el[$];
   int acc[81];
   int sent, cyc, fd_cnt, fd_cyc, ir_low, first_pop, tmo;

   multi_crop_fifo #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_y1(cfg_y1), .cfg_x1(cfg_x1), .cfg_en(cfg_en),
      .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(in_ready),
      .pixel_out(pixel_out), .out_valid(out_valid), .out_ready(out_ready),
      .out_crop_id(out_crop_id), .out_last(out_last), .frame_done(frame_done),
      .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic setcfg(input int y0, input int x0, input int y1, input int x1, input logic [1:0] en);
      cfg_y1 = {4'(y1), 4'(y0)};
      cfg_x1 = {4'(x1), 4'(x0)};
      cfg_en = en;
   endtask

   task automatic ex(input int p, input int id, input int last);
      ep.push_back(p); ei.push_back(id); el.push_back(last);
   endtask

   task automatic add_crop(input int id, input int y, input int x);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            ex((y + r) * 9 + x + c, id, (r == 2 && c == 2) ? 1 : 0);
   endtask

   task automatic clr_exp();
      ep.delete(); ei.delete(); el.delete();
   endtask

   // Drives nbeats raster pixels; out_ready held low for `hold` cycles, optional random gaps.
   task automatic run(input int nbeats, input int hold, input bit rnd);
      bit done = 0;
      gp.delete(); gi.delete(); gl.delete();
      sent = 0; cyc = 0; fd_cnt = 0; fd_cyc = -1; ir_low = -1; first_pop = -1; tmo = 0;
      while (!done) begin
         @(negedge clk);
         if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
         in_valid  = (sent < nbeats) && (!rnd || $urandom_range(0, 1) == 1);
         pixel_in  = 8'(sent);
         out_ready = (cyc >= hold) && (!rnd || $urandom_range(0, 3) != 0);
         #1;
         if (!in_ready && ir_low < 0) ir_low = cyc;
         if (in_valid && in_ready) begin acc[sent] = cyc; sent++; end
         if (out_valid && out_ready) begin
            if (first_pop < 0) first_pop = cyc;
            gp.push_back(int'(pixel_out)); gi.push_back(int'(out_crop_id)); gl.push_back(int'(out_last));
         end
         cyc++;
         if (sent == nbeats && (nbeats < 81 || (!out_valid && cyc > acc[80] + 2))) done = 1;
         if (cyc > 3000) begin tmo = 1; done = 1; end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("cycle budget", tmo, 0);
      if (nbeats == 81) begin
         chk("frame_done count", fd_cnt, 1);
         chk("frame_done timing", fd_cyc, acc[80] + 1);
      end
   endtask

   task automatic cmp(input string tag);
      chk({tag, " length"}, gp.size(), ep.size());
      for (int i = 0; i < ep.size() && i < gp.size(); i++) begin
         chk({tag, " pixel"}, gp[i], ep[i]);
         chk({tag, " crop_id"}, gi[i], ei[i]);
         chk({tag, " last"}, gl[i], el[i]);
      end
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pixel_in = '0;
      cfg_y1 = '0; cfg_x1 = '0; cfg_en = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset in_ready", in_ready, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset pixel_out", pixel_out, 0);
      chk("reset crop_id", out_crop_id, 0);
      chk("reset last", out_last, 0);
      chk("reset frame_done", frame_done, 0);
      chk("reset cfg_err", cfg_err, 0);
      reset_n = 1'b1;
      #1 chk("post-reset in_ready", in_ready, 1);

      // single crop at (2,2)
      setcfg(2, 2, 0, 0, 2'b01);
      clr_exp(); add_crop(0, 2, 2);
      run(81, 0, 0);
      cmp("single");
      chk("single latency", first_pop, acc[20] + 1);

      // two crops at (0,0) and (6,6)
      setcfg(0, 0, 6, 6, 2'b11);
      clr_exp(); add_crop(0, 0, 0); add_crop(1, 6, 6);
      run(81, 0, 0);
      cmp("dual");

      // backpressure: depth-4 FIFO fills with 0,1,2,9
      setcfg(0, 0, 0, 0, 2'b01);
      clr_exp(); add_crop(0, 0, 0);
      run(81, 15, 0);
      chk("backpressure in_ready", ir_low, acc[9] + 1);
      cmp("backpressure");

      // overlap (2,2)/(3,3): crop 0 shadows 30,31,39,40
      setcfg(2, 2, 3, 3, 2'b11);
      clr_exp();
      ex(20,0,0); ex(21,0,0); ex(22,0,0); ex(29,0,0); ex(30,0,0); ex(31,0,0); ex(32,1,0);
      ex(38,0,0); ex(39,0,0); ex(40,0,1); ex(41,1,0); ex(48,1,0); ex(49,1,0); ex(50,1,1);
      run(81, 0, 0);
      cmp("overlap");

      // crop 0 out of bounds at x1=7
      setcfg(0, 7, 0, 0, 2'b11);
      clr_exp(); add_crop(1, 0, 0);
      run(81, 0, 0);
      cmp("cfg_err frame");
      chk("cfg_err set", cfg_err, 2'b01);

      // x1=6 fits exactly; error clears on the new latch
      setcfg(0, 6, 0, 0, 2'b11);
      clr_exp();
      ex(0,1,0); ex(1,1,0); ex(2,1,0); ex(6,0,0); ex(7,0,0); ex(8,0,0);
      ex(9,1,0); ex(10,1,0); ex(11,1,0); ex(15,0,0); ex(16,0,0); ex(17,0,0);
      ex(18,1,0); ex(19,1,0); ex(20,1,1); ex(24,0,0); ex(25,0,0); ex(26,0,1);
      run(81, 0, 0);
      cmp("cfg_err clear frame");
      chk("cfg_err cleared", cfg_err, 2'b00);

      // mid-frame reset with data buffered
      setcfg(2, 2, 0, 0, 2'b01);
      run(25, 1000, 0);
      @(negedge clk);
      #1 chk("pre-reset out_valid", out_valid, 1);
      reset_n = 1'b0;
      #1;
      chk("mid reset out_valid", out_valid, 0);
      chk("mid reset pixel_out", pixel_out, 0);
      chk("mid reset in_ready", in_ready, 0);
      @(negedge clk);
      reset_n = 1'b1;
      clr_exp(); add_crop(0, 2, 2);
      run(81, 0, 0);
      cmp("after reset");
      chk("after reset latency", first_pop, acc[20] + 1);

      // random in_valid/out_ready over several frames
      setcfg(0, 0, 6, 6, 2'b11);
      clr_exp(); add_crop(0, 0, 0); add_crop(1, 6, 6);
      for (int f = 0; f < 6; f++) begin
         run(81, 0, 1);
         cmp("soak");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
